// File: rtl/if_pkg.sv
// Shared types for the prefetch instruction-fetch stage: queue entry layout,
// fetch FSM states and the JAL immediate decoder used by the optional predictor.
package if_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br_pred;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Sign-extended J-type immediate of a JAL instruction.
  function automatic logic [31:0] jal_offset(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/prefetch_if_stage_if.sv
// Instruction-cache read bus between the fetch stage (master) and the icache (slave).
// One outstanding request; the response arrives as a single-cycle valid pulse.
interface prefetch_if_stage_if;
  logic        mem_read_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;

  modport master (output mem_read_o, output mem_addr_o, input mem_valid_i, input mem_data_i);
  modport slave  (input mem_read_o, input mem_addr_o, output mem_valid_i, output mem_data_i);
endinterface

// File: rtl/branch_predictor.sv
// Static JAL predictor: a fetched JAL is predicted taken to pc + J-immediate.
// Only compiled when IF_BRANCH_PRED_EN is defined.
`ifdef IF_BRANCH_PRED_EN
module branch_predictor
  import if_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        taken,
  output logic [31:0] target
);
  assign taken  = (instr[6:0] == 7'b1101111);
  assign target = pc + jal_offset(instr);
endmodule
`endif

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two ring buffer with wrapping pointers and an occupancy count.
// The head entry is read straight out of the registered storage.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn_i,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage has no reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign rdata = mem_q[rd_ptr];

endmodule

// File: rtl/prefetch_if_stage.sv
// Prefetch instruction-fetch stage: IDLE/REQ/DROP fetch FSM feeding a fetch_fifo queue.
// Define IF_BRANCH_PRED_EN to steer sequential fetch with the static JAL predictor.
module prefetch_if_stage
  import if_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  input  logic                          halt_i,
  input  logic                          branch_i,
  input  logic [31:0]                   pc_i,
  input  logic                          ack_i,
  output logic                          valid_o,
  output logic [31:0]                   instr_o,
  output logic [31:0]                   pc_o,
  output logic                          br_pred_o,
  prefetch_if_stage_if.master           mem,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic [31:0]                   dbg_pc_o
);
  localparam int              CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   FULL = CW'(FIFO_DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  logic         redirect;
  logic         issue;
  logic         push;
  logic         pop;
  logic         pred_br;
  logic [31:0]  pred_pc;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign redirect = flush_i | branch_i;

`ifdef IF_BRANCH_PRED_EN
  branch_predictor u_bp (
    .instr  (mem.mem_data_i),
    .pc     (pc_q),
    .taken  (pred_br),
    .target (pred_pc)
  );
`else
  assign pred_br = 1'b0;
  assign pred_pc = pc_q + 32'd4;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_o != FULL && !halt_i && !redirect) begin
          state_d = REQ;
          issue   = 1'b1;
        end
      end
      REQ: begin
        if (mem.mem_valid_i) begin
          state_d = IDLE;
          push    = !redirect;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem.mem_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request address is latched at issue so a redirect never disturbs the bus.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (issue) addr_q <= pc_q;
      if (redirect)  pc_q <= pc_i;
      else if (push) pc_q <= pred_br ? pred_pc : pc_q + 32'd4;
    end
  end

  assign pop      = valid_o & ack_i & ~flush_i;
  assign wr_entry = '{instr: mem.mem_data_i, pc: addr_q, br_pred: pred_br};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rstn_i (rstn_i),
    .flush  (flush_i),
    .push   (push),
    .pop    (pop),
    .wdata  (wr_entry),
    .rdata  (head),
    .count  (fill_o)
  );

  assign mem.mem_read_o = (state_q != IDLE);
  assign mem.mem_addr_o = mem.mem_read_o ? addr_q : '0;

  assign valid_o   = (fill_o != '0);
  assign instr_o   = valid_o ? head.instr : '0;
  assign pc_o      = valid_o ? head.pc : '0;
  assign br_pred_o = valid_o & head.br_pred;
  assign dbg_pc_o  = pc_q;

endmodule

// File: tb/tb_prefetch_if_stage.sv
// Self-checking bench for prefetch_if_stage: an icache responder plus a queue-level
// reference model, directed scenarios and a randomized run of redirects, halts and acks.
module tb_prefetch_if_stage;
  import if_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        ack_i = 1'b0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        br_pred_o;
  logic [2:0]  fill_o;
  logic [31:0] dbg_pc_o;

  prefetch_if_stage_if mem_bus ();

  prefetch_if_stage #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .flush_i   (flush_i),
    .halt_i    (halt_i),
    .branch_i  (branch_i),
    .pc_i      (pc_i),
    .ack_i     (ack_i),
    .valid_o   (valid_o),
    .instr_o   (instr_o),
    .pc_o      (pc_o),
    .br_pred_o (br_pred_o),
    .mem       (mem_bus),
    .fill_o    (fill_o),
    .dbg_pc_o  (dbg_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] model_pc;
  logic [31:0] req_log[$];
  bit          in_req;
  bit          dropped;
  int          req_age;
  int          resp_lat = 1;
  bit          resp_en = 1'b1;
  logic [31:0] cur_addr;
  bit          jal_at_20 = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] icache(input logic [31:0] a);
    if (jal_at_20 && a == 32'h20) return 32'h0400_006F;  // jal x0, +0x40
    return {a[24:0], 7'b0010011};
  endfunction

`ifdef IF_BRANCH_PRED_EN
  function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] ins);
    int imm;
    imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
          + int'(ins[30:21]) * 2;
    return pc + 32'(imm);
  endfunction
`endif

  function automatic logic [31:0] last_req();
    return (req_log.size() != 0) ? req_log[req_log.size()-1] : 32'hDEAD_BEEF;
  endfunction

  // One clock: answer the icache, advance the model for the coming edge, compare after it.
  task automatic step();
    ent_t        e;
    ent_t        h;
    bit          push_m;
    bit          pop_m;
    bit          redirect;
    logic [31:0] nxt;
    if (mem_bus.mem_read_o === 1'b1) begin
      if (!in_req) begin
        in_req   = 1'b1;
        dropped  = 1'b0;
        req_age  = 0;
        cur_addr = mem_bus.mem_addr_o;
        req_log.push_back(cur_addr);
        n_checks++;
        if (cur_addr !== model_pc) $display("FAIL req_addr: got %h want %h", cur_addr, model_pc);
        else n_pass++;
      end else begin
        n_checks++;
        if (mem_bus.mem_addr_o !== cur_addr)
          $display("FAIL addr_stable: got %h want %h", mem_bus.mem_addr_o, cur_addr);
        else n_pass++;
      end
      req_age++;
      if (resp_en && req_age >= resp_lat) begin
        mem_bus.mem_valid_i = 1'b1;
        mem_bus.mem_data_i  = icache(cur_addr);
      end else begin
        mem_bus.mem_valid_i = 1'b0;
        mem_bus.mem_data_i  = $urandom;
      end
    end else begin
      in_req = 1'b0;
      mem_bus.mem_valid_i = 1'b0;
      mem_bus.mem_data_i  = $urandom;
    end

    redirect = flush_i || branch_i;
    if (in_req && redirect) dropped = 1'b1;
    push_m  = in_req && mem_bus.mem_valid_i && !dropped;
    pop_m   = (model_q.size() != 0) && ack_i && !flush_i;
    e.instr = mem_bus.mem_data_i;
    e.pc    = cur_addr;
    e.br    = 1'b0;
    nxt     = cur_addr + 32'd4;
`ifdef IF_BRANCH_PRED_EN
    if (e.instr[6:0] == 7'h6F) begin
      e.br = 1'b1;
      nxt  = jal_target(cur_addr, e.instr);
    end
`endif
    if (flush_i) model_q.delete();
    else begin
      if (pop_m)  void'(model_q.pop_front());
      if (push_m) model_q.push_back(e);
    end
    if (redirect)    model_pc = pc_i;
    else if (push_m) model_pc = nxt;
    if (push_m) in_req = 1'b1;

    @(posedge clk);
    @(negedge clk);

    n_checks++;
    if (fill_o !== 3'(model_q.size())) $display("FAIL fill: got %0d want %0d", fill_o, model_q.size());
    else n_pass++;
    n_checks++;
    if (valid_o !== (model_q.size() != 0)) $display("FAIL valid: got %b want %b", valid_o, model_q.size() != 0);
    else n_pass++;
    n_checks++;
    if (dbg_pc_o !== model_pc) $display("FAIL dbg_pc: got %h want %h", dbg_pc_o, model_pc);
    else n_pass++;
    if (model_q.size() != 0) begin
      h = model_q[0];
      n_checks++;
      if ({instr_o, pc_o, br_pred_o} !== {h.instr, h.pc, h.br})
        $display("FAIL head: got %h/%h/%b want %h/%h/%b", instr_o, pc_o, br_pred_o, h.instr, h.pc, h.br);
      else n_pass++;
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_pc = RST_PC;
    in_req   = 1'b0;
    mem_bus.mem_valid_i = 1'b0;
    mem_bus.mem_data_i  = '0;
  endtask

  task automatic test_reset();
    model_reset();
    req_log.delete();
    rstn_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_bus.mem_read_o, mem_bus.mem_addr_o} !== 33'd0)
      $display("FAIL reset_bus: got %b/%h want 0/0", mem_bus.mem_read_o, mem_bus.mem_addr_o);
    else n_pass++;
    n_checks++;
    if ({valid_o, instr_o, pc_o, br_pred_o, fill_o, dbg_pc_o} !== {66'd0, 3'd0, RST_PC})
      $display("FAIL reset_out: got %b/%h/%h/%b/%0d/%h", valid_o, instr_o, pc_o, br_pred_o, fill_o, dbg_pc_o);
    else n_pass++;
    rstn_i = 1'b1;
    step();
    n_checks++;
    if (mem_bus.mem_read_o !== 1'b1) $display("FAIL first_read: got %b want 1", mem_bus.mem_read_o);
    else n_pass++;
  endtask

  task automatic test_fill();
    ack_i = 1'b0; resp_lat = 1; resp_en = 1'b1;
    for (int i = 0; i < 20 && model_q.size() < DEPTH; i++) step();
    n_checks++;
    if (fill_o !== 3'd4) $display("FAIL fill_full: got %0d want 4", fill_o);
    else n_pass++;
    n_checks++;
    if (req_log.size() != 4 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 ||
        req_log[2] !== 32'h8 || req_log[3] !== 32'hC)
      $display("FAIL fill_addrs: got %0d requests, last %h want 0,4,8,c", req_log.size(), last_req());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (mem_bus.mem_read_o !== 1'b0) $display("FAIL full_no_read: got %b want 0", mem_bus.mem_read_o);
      else n_pass++;
    end
  endtask

  task automatic test_pop_refill();
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    n_checks++;
    if (fill_o !== 3'd3) $display("FAIL pop_fill: got %0d want 3", fill_o);
    else n_pass++;
    for (int i = 0; i < 10 && req_log.size() < 5; i++) step();
    n_checks++;
    if (req_log.size() != 5 || last_req() !== 32'h10)
      $display("FAIL refill_addr: got %h (%0d requests) want 10", last_req(), req_log.size());
    else n_pass++;
  endtask

  task automatic test_flush();
    int n0;
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    resp_lat = 4;
    for (int i = 0; i < 10 && mem_bus.mem_read_o !== 1'b1; i++) step();
    flush_i = 1'b1; pc_i = 32'h200;
    step();
    flush_i = 1'b0;
    n_checks++;
    if (fill_o !== 3'd0) $display("FAIL flush_fill: got %0d want 0", fill_o);
    else n_pass++;
    n0 = req_log.size();
    for (int i = 0; i < 15 && req_log.size() == n0; i++) step();
    n_checks++;
    if (req_log.size() == n0 || last_req() !== 32'h200)
      $display("FAIL flush_addr: got %h want 200", last_req());
    else n_pass++;
  endtask

  task automatic test_halt_branch();
    int n0;
    resp_lat = 1; ack_i = 1'b0;
    for (int i = 0; i < 20 && model_q.size() != 2; i++) step();
    halt_i = 1'b1;
    step();
    n_checks++;
    if (mem_bus.mem_read_o !== 1'b0) $display("FAIL halt_read: got %b want 0", mem_bus.mem_read_o);
    else n_pass++;
    branch_i = 1'b1; pc_i = 32'h80;
    step();
    branch_i = 1'b0;
    n_checks++;
    if (fill_o !== 3'd2 || pc_o !== 32'h200) $display("FAIL branch_keep: got %0d/%h want 2/200", fill_o, pc_o);
    else n_pass++;
    halt_i = 1'b0;
    n0 = req_log.size();
    for (int i = 0; i < 10 && req_log.size() == n0; i++) step();
    n_checks++;
    if (req_log.size() == n0 || last_req() !== 32'h80)
      $display("FAIL branch_addr: got %h want 80", last_req());
    else n_pass++;
  endtask

  task automatic test_wrap();
    ack_i = 1'b1;
    flush_i = 1'b1; pc_i = 32'hFFFF_FFFC;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 10 && model_q.size() == 0; i++) step();
    ack_i = 1'b0;
    n_checks++;
    if (pc_o !== 32'hFFFF_FFFC || dbg_pc_o !== 32'h0)
      $display("FAIL wrap: got %h/%h want fffffffc/00000000", pc_o, dbg_pc_o);
    else n_pass++;
  endtask

`ifdef IF_BRANCH_PRED_EN
  task automatic test_branch_pred();
    int n0;
    jal_at_20 = 1'b1; ack_i = 1'b0;
    flush_i = 1'b1; pc_i = 32'h20;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 10 && model_q.size() == 0; i++) step();
    n_checks++;
    if (br_pred_o !== 1'b1 || pc_o !== 32'h20) $display("FAIL pred_entry: got %b/%h want 1/20", br_pred_o, pc_o);
    else n_pass++;
    n0 = req_log.size();
    for (int i = 0; i < 10 && req_log.size() == n0; i++) step();
    n_checks++;
    if (req_log.size() == n0 || last_req() !== 32'h60) $display("FAIL pred_addr: got %h want 60", last_req());
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ack_i    = ($urandom_range(0, 2) != 0);
      halt_i   = ($urandom_range(0, 7) == 0);
      flush_i  = ($urandom_range(0, 31) == 0);
      branch_i = ($urandom_range(0, 23) == 0);
      pc_i     = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 255)) << 2;
      resp_lat = $urandom_range(1, 3);
      step();
    end
    ack_i = 1'b0; halt_i = 1'b0; flush_i = 1'b0; branch_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b0;
    for (int i = 0; i < 10 && mem_bus.mem_read_o !== 1'b1; i++) step();
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({mem_bus.mem_read_o, mem_bus.mem_addr_o, valid_o, fill_o, dbg_pc_o} !== {34'd0, 3'd0, RST_PC})
      $display("FAIL mid_reset: got %b/%h/%b/%0d/%h", mem_bus.mem_read_o, mem_bus.mem_addr_o, valid_o, fill_o, dbg_pc_o);
    else n_pass++;
    model_reset();
    resp_en = 1'b1;
    @(negedge clk);
    rstn_i = 1'b1;
    step();
    n_checks++;
    if (mem_bus.mem_read_o !== 1'b1 || mem_bus.mem_addr_o !== RST_PC)
      $display("FAIL post_reset_req: got %b/%h want 1/%h", mem_bus.mem_read_o, mem_bus.mem_addr_o, RST_PC);
    else n_pass++;
    repeat (4) step();
  endtask

  initial begin
    mem_bus.mem_valid_i = 1'b0;
    mem_bus.mem_data_i  = '0;
    test_reset();
    test_fill();
    test_pop_refill();
    test_flush();
    test_halt_branch();
    test_wrap();
`ifdef IF_BRANCH_PRED_EN
    test_branch_pred();
`endif
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prefetch_if_stage.md
PREFETCH_IF_STAGE -- requirements
Module: prefetch_if_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, prefetch queue entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port flush_i  input  1  empty the queue, drop any in-flight fetch, redirect to pc_i.
REQ-006 SHALL have port halt_i  input  1  suppress new fetch requests.
REQ-007 SHALL have port branch_i  input  1  redirect fetch to pc_i, drop any in-flight fetch, keep the queue.
REQ-008 SHALL have port pc_i  input  32  redirect target.
REQ-009 SHALL have port ack_i  input  1  downstream consumes the head entry.
REQ-010 SHALL have ports valid_o, instr_o[31:0], pc_o[31:0], br_pred_o  output  queue-head entry.
REQ-011 SHALL have ports mem_read_o (1), mem_addr_o (32)  output  icache read request.
REQ-012 SHALL have ports mem_valid_i (1), mem_data_i (32)  input  icache one-cycle response.
REQ-013 SHALL have port fill_o  output  $clog2(FIFO_DEPTH)+1  queue occupancy.
REQ-014 SHALL have port dbg_pc_o  output  32  current fetch pc (pc_q).

Function
REQ-015 SHALL run a fetch FSM with states IDLE, REQ, DROP.
REQ-016 IDLE->REQ SHALL occur when fill_o < FIFO_DEPTH, !halt_i, !flush_i, !branch_i.
REQ-017 In REQ and DROP, mem_read_o SHALL be 1 and mem_addr_o stable until mem_valid_i; in IDLE, mem_read_o SHALL be 0.
REQ-018 REQ + mem_valid_i SHALL push {mem_data_i, pc_q, pred_br}, advance pc_q, and go to IDLE.
REQ-019 Advance SHALL be pc_q <= pred_br ? pred_pc : pc_q + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-020 REQ + (flush_i or branch_i) without mem_valid_i SHALL go to DROP; with mem_valid_i, the response SHALL be discarded and the FSM SHALL go to IDLE.
REQ-021 DROP SHALL discard the response on mem_valid_i and go to IDLE; an in-flight request is never aborted.
REQ-022 flush_i or branch_i SHALL load pc_q <= pc_i on that edge; redirect SHALL take priority over advance.
REQ-023 flush_i SHALL empty the queue on that edge; ack_i in the same cycle SHALL be ignored.
REQ-024 valid_o SHALL equal (fill_o != 0); the head fields SHALL come from registered queue storage.
REQ-025 Pop on valid_o && ack_i; simultaneous push and pop SHALL leave fill_o unchanged.
REQ-026 Push SHALL never see a full queue, because a request issues only when fill_o < FIFO_DEPTH and at most one request is outstanding.
REQ-027 halt_i SHALL block only new requests; an in-flight fetch completes and pushes, and pops continue.
REQ-028 Latency: response in cycle k SHALL give valid_o=1 in cycle k+1 when the queue was empty.

Reset
REQ-029 Asserting rstn_i SHALL set pc_q=RESET_PC, FSM=IDLE, queue empty, and all outputs 0 except dbg_pc_o=RESET_PC, asynchronously, including mid-request.
REQ-030 The first mem_read_o SHALL assert in the first cycle after rstn_i deasserts.

Configuration
REQ-031 With IF_BRANCH_PRED_EN defined, the block SHALL instantiate branch_predictor on (mem_data_i, pc_q) to produce pred_br and pred_pc.
REQ-032 Without IF_BRANCH_PRED_EN, pred_br SHALL be 0, br_pred_o SHALL always be 0, and fetch SHALL be strictly sequential.

Structure
REQ-033 Package if_pkg SHALL hold the fetch_entry_t struct {instr, pc, br_pred} and the fetch_state_t enum.
REQ-034 Queue storage SHALL be a sub-module fetch_fifo (parametrised by FIFO_DEPTH, wrapping pointers, count), instantiated once.

Verification
REQ-035 Reset release, icache answers every 2nd cycle, ack_i=0 -> 4 pushes with pc 0,4,8,C; fill_o=4; mem_read_o=0 after that.
REQ-036 Queue full, ack_i=1 for one cycle -> fill_o=3, then one new request at address 0x10.
REQ-037 flush_i with pc_i=0x200 during REQ, response 3 cycles later -> response discarded, fill_o=0, next request address 0x200.
REQ-038 branch_i with pc_i=0x80, queue holding 2 entries -> entries kept, next request address 0x80.
REQ-039 pc_q=0xFFFF_FFFC, sequential response -> pc_q=0x0000_0000.
REQ-040 IF_BRANCH_PRED_EN defined, JAL +0x40 fetched at 0x20 -> br_pred_o=1 on that entry, next request address 0x60.
